dmem_access_ctrl: RTL and testbench

Sits directly upstream of the data memory (word-addressed, asynchronous read, synchronous write) and owns its only port.
Arbitrates between the CPU load/store path and the PDU debug port.
Converts CPU byte-addressed byte/half/word accesses into word accesses, with read-modify-write merge for sub-word stores and sign/zero extension for loads.
Flags misaligned CPU accesses instead of performing them.

---
 rtl/dmem_access_ctrl_pkg.sv | 21 ++
 rtl/dmem_access_ctrl_lane_align.sv | 54 +++++
 rtl/dmem_access_ctrl.sv | 148 ++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_access_ctrl_pkg.sv
// Shared encodings for the data-memory access controller: access sizes,
// controller FSM states and arbitration grant identifiers.
package dmem_access_ctrl_pkg;

    // CPU access size encodings (2'b11 is illegal)
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        GNT_CPU = 1'b0,
        GNT_PDU = 1'b1
    } grant_t;

endpackage

// File: rtl/dmem_access_ctrl_lane_align.sv
// Byte-lane steering between a 32-bit memory word and a right-aligned
// CPU operand: load extraction with sign/zero extension, store merge of
// the addressed lanes into the current word, and alignment checking.
module dmem_lane_align
    import dmem_access_ctrl_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        is_unsigned,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word,
    output logic        misaligned
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;
    logic [4:0]  byte_shift;
    logic [4:0]  half_shift;

    assign byte_shift = {offset, 3'b000};
    assign half_shift = {offset[1], 4'b0000};

    // Select lanes for the addressed size and build both load and store results
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path infers a latch.
        misaligned = 1'b0;
        load_data  = rdata;
        store_word = rdata;
        byte_val   = rdata[byte_shift +: 8];
        half_val   = rdata[half_shift +: 16];
        case (size)
            SZ_B: begin
                load_data = is_unsigned ? {24'h0, byte_val} : {{24{byte_val[7]}}, byte_val};
                store_word[byte_shift +: 8] = wdata[7:0];
            end
            SZ_H: begin
                misaligned = offset[0];
                load_data  = is_unsigned ? {16'h0, half_val} : {{16{half_val[15]}}, half_val};
                store_word[half_shift +: 16] = wdata[15:0];
            end
            SZ_W: begin
                misaligned = (offset != 2'b00);
                load_data  = rdata;
                store_word = wdata;
            end
            default: begin
                misaligned = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: owns the single memory port, arbitrates
// CPU vs PDU with alternating priority on conflict, and runs each access
// through IDLE -> ACCESS -> RESP (one access every three cycles).
module dmem_access_ctrl
    import dmem_access_ctrl_pkg::*;
#(
    parameter int DEPTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [31:0]      cpu_addr,
    input  logic [1:0]       cpu_size,
    input  logic             cpu_unsigned,
    input  logic [31:0]      cpu_wdata,
    output logic [31:0]      cpu_rdata,
    output logic             cpu_ack,
    output logic             cpu_ale,
    input  logic             pdu_req,
    input  logic             pdu_we,
    input  logic [DEPTH-1:0] pdu_addr,
    input  logic [31:0]      pdu_wdata,
    output logic [31:0]      pdu_rdata,
    output logic             pdu_ack,
    output logic [DEPTH-1:0] mem_addr,
    input  logic [31:0]      mem_rdata,
    output logic [31:0]      mem_wdata,
    output logic             mem_we
);

    state_t      state;
    state_t      state_nx;
    grant_t      grant;        // also serves as last_grant for arbitration
    logic        pick_pdu;
    logic        start;

    // Latched request fields; PDU requests are latched as aligned full words
    logic        lat_we;
    logic [1:0]  lat_size;
    logic [1:0]  lat_off;
    logic        lat_uns;
    logic [31:0] lat_wdata;

    logic [31:0] load_data;
    logic [31:0] store_word;
    logic        misaligned;

    // Address bits above the memory window alias and are deliberately dropped
    logic        unused_addr_hi;
    assign unused_addr_hi = ^cpu_addr[31:DEPTH+2];

    // On conflict the requester that did not win last time is served
    assign start    = cpu_req || pdu_req;
    assign pick_pdu = pdu_req && (!cpu_req || (grant == GNT_CPU));

    dmem_lane_align u_lane_align (
        .size        (lat_size),
        .offset      (lat_off),
        .is_unsigned (lat_uns),
        .rdata       (mem_rdata),
        .wdata       (lat_wdata),
        .load_data   (load_data),
        .store_word  (store_word),
        .misaligned  (misaligned)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // FSM next-state logic; requests are only looked at in IDLE
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = ACCESS;
            ACCESS:  state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // FSM outputs: ack pulses in RESP, memory write strobe only in ACCESS
    always_comb begin
        cpu_ack   = (state == RESP) && (grant == GNT_CPU);
        pdu_ack   = (state == RESP) && (grant == GNT_PDU);
        mem_we    = (state == ACCESS) && lat_we && !misaligned && !rst;
        mem_wdata = ((state == ACCESS) && lat_we) ? store_word : 32'h0;
    end

    // Grant latch: capture the winning request and its memory word address
    always_ff @(posedge clk) begin
        if (rst) begin
            grant     <= GNT_CPU;
            mem_addr  <= '0;
            lat_we    <= 1'b0;
            lat_size  <= SZ_B;
            lat_off   <= 2'b00;
            lat_uns   <= 1'b0;
            lat_wdata <= 32'h0;
        end else if ((state == IDLE) && start) begin
            if (pick_pdu) begin
                grant     <= GNT_PDU;
                mem_addr  <= pdu_addr;
                lat_we    <= pdu_we;
                lat_size  <= SZ_W;
                lat_off   <= 2'b00;
                lat_uns   <= 1'b0;
                lat_wdata <= pdu_wdata;
            end else begin
                grant     <= GNT_CPU;
                mem_addr  <= cpu_addr[DEPTH+1:2];
                lat_we    <= cpu_we;
                lat_size  <= cpu_size;
                lat_off   <= cpu_addr[1:0];
                lat_uns   <= cpu_unsigned;
                lat_wdata <= cpu_wdata;
            end
        end
    end

    // Response registers: loaded during ACCESS, presented with the ack in RESP
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_rdata <= 32'h0;
            cpu_ale   <= 1'b0;
            pdu_rdata <= 32'h0;
        end else if (state == ACCESS) begin
            if (grant == GNT_CPU) begin
                cpu_ale <= misaligned;
                if (misaligned) begin
                    cpu_rdata <= 32'h0;
                end else if (!lat_we) begin
                    cpu_rdata <= load_data;
                end
            end else if (!lat_we) begin
                pdu_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: a behavioural word memory on
// the memory port, directed CPU/PDU accesses, and an ack-driven scoreboard.
module tb_dmem_access_ctrl;
    import dmem_access_ctrl_pkg::*;

    localparam int DEPTH = 10;

    logic             clk;
    logic             rst;
    logic             cpu_req;
    logic             cpu_we;
    logic [31:0]      cpu_addr;
    logic [1:0]       cpu_size;
    logic             cpu_unsigned;
    logic [31:0]      cpu_wdata;
    logic [31:0]      cpu_rdata;
    logic             cpu_ack;
    logic             cpu_ale;
    logic             pdu_req;
    logic             pdu_we;
    logic [DEPTH-1:0] pdu_addr;
    logic [31:0]      pdu_wdata;
    logic [31:0]      pdu_rdata;
    logic             pdu_ack;
    logic [DEPTH-1:0] mem_addr;
    logic [31:0]      mem_rdata;
    logic [31:0]      mem_wdata;
    logic             mem_we;

    logic [31:0] mem [0:(1<<DEPTH)-1];

    typedef struct {
        logic [31:0] rdata;
        logic        ale;
        bit          chk;
        int          cyc;
    } exp_t;

    exp_t cpu_q[$];
    exp_t pdu_q[$];
    exp_t ce;
    exp_t pe;

    int cyc    = 0;
    int n_cmp  = 0;
    int n_err  = 0;
    int we_cnt = 0;
    int we_cyc = -1;
    int w0;
    int c0;

    dmem_access_ctrl #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_req      (cpu_req),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_size     (cpu_size),
        .cpu_unsigned (cpu_unsigned),
        .cpu_wdata    (cpu_wdata),
        .cpu_rdata    (cpu_rdata),
        .cpu_ack      (cpu_ack),
        .cpu_ale      (cpu_ale),
        .pdu_req      (pdu_req),
        .pdu_we       (pdu_we),
        .pdu_addr     (pdu_addr),
        .pdu_wdata    (pdu_wdata),
        .pdu_rdata    (pdu_rdata),
        .pdu_ack      (pdu_ack),
        .mem_addr     (mem_addr),
        .mem_rdata    (mem_rdata),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural data memory: asynchronous read, synchronous write
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops an expectation on every ack and compares it
    always @(negedge clk) begin
        if (mem_we) begin
            we_cnt++;
            we_cyc = cyc;
        end
        if (cpu_ack) begin
            if (cpu_q.size() == 0) begin
                check("cpu_unexpected_ack", 1, 0);
            end else begin
                ce = cpu_q.pop_front();
                check("cpu_ack_cycle", cyc, ce.cyc);
                check("cpu_ale", cpu_ale, ce.ale);
                if (ce.chk) check("cpu_rdata", cpu_rdata, ce.rdata);
            end
        end
        if (pdu_ack) begin
            if (pdu_q.size() == 0) begin
                check("pdu_unexpected_ack", 1, 0);
            end else begin
                pe = pdu_q.pop_front();
                check("pdu_ack_cycle", cyc, pe.cyc);
                if (pe.chk) check("pdu_rdata", pdu_rdata, pe.rdata);
            end
        end
    end

    task automatic cpu_do(input logic we, input logic [31:0] addr, input logic [1:0] size,
                          input logic uns, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_ale,
                          input bit chk, input int lat);
        exp_t e;
        bit   seen;
        e.rdata = exp_rdata;
        e.ale   = exp_ale;
        e.chk   = chk;
        e.cyc   = cyc + lat;
        cpu_q.push_back(e);
        cpu_we       = we;
        cpu_addr     = addr;
        cpu_size     = size;
        cpu_unsigned = uns;
        cpu_wdata    = wdata;
        cpu_req      = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (cpu_ack) seen = 1'b1;
        end
        if (!seen) check("cpu_ack_timeout", 0, 1);
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
    endtask

    task automatic pdu_do(input logic we, input logic [DEPTH-1:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input bit chk, input int lat);
        exp_t e;
        bit   seen;
        e.rdata = exp_rdata;
        e.ale   = 1'b0;
        e.chk   = chk;
        e.cyc   = cyc + lat;
        pdu_q.push_back(e);
        pdu_we    = we;
        pdu_addr  = addr;
        pdu_wdata = wdata;
        pdu_req   = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (pdu_ack) seen = 1'b1;
        end
        if (!seen) check("pdu_ack_timeout", 0, 1);
        @(posedge clk);
        #1;
        pdu_req = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_flags"},     {cpu_ack, pdu_ack, cpu_ale, mem_we}, 4'b0000);
        check({tag, "_cpu_rdata"}, cpu_rdata, 32'h0);
        check({tag, "_pdu_rdata"}, pdu_rdata, 32'h0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        check({tag, "_mem_addr"},  mem_addr,  '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1 << DEPTH); i++) mem[i] = 32'h0;
        mem[1] = 32'h8899AABB;
        mem[2] = 32'h01020304;
        mem[3] = 32'h33333333;
        rst = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_size = SZ_W;
        cpu_unsigned = 1'b0; cpu_wdata = 32'h0;
        pdu_req = 1'b0; pdu_we = 1'b0; pdu_addr = '0; pdu_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;

        // First conflict after reset: PDU wins, CPU follows three cycles later
        fork
            cpu_do(1'b0, 32'h5, SZ_B, 1'b1, 32'h0, 32'h000000AA, 1'b0, 1'b1, 5);
            pdu_do(1'b0, 10'd3, 32'h0, 32'h33333333, 1'b1, 2);
        join

        // PDU write then read-back of word 3
        pdu_do(1'b1, 10'd3, 32'hDEADBEEF, 32'h0, 1'b0, 2);
        pdu_do(1'b0, 10'd3, 32'h0, 32'hDEADBEEF, 1'b1, 2);
        check("pdu_wr_mem3", mem[3], 32'hDEADBEEF);

        // Second conflict: PDU was last served, so the CPU goes first
        fork
            cpu_do(1'b0, 32'h5, SZ_B, 1'b0, 32'h0, 32'hFFFFFFAA, 1'b0, 1'b1, 2);
            pdu_do(1'b0, 10'd3, 32'h0, 32'hDEADBEEF, 1'b1, 5);
        join

        // Half store into upper lanes: one write strobe in the ACCESS cycle
        w0 = we_cnt;
        c0 = cyc;
        cpu_do(1'b1, 32'h6, SZ_H, 1'b0, 32'hCAFE1234, 32'h0, 1'b0, 1'b0, 2);
        check("sth_we_count", we_cnt - w0, 1);
        check("sth_we_cycle", we_cyc, c0 + 1);
        check("sth_mem1", mem[1], 32'h1234AABB);

        cpu_do(1'b0, 32'h4, SZ_W, 1'b0, 32'h0, 32'h1234AABB, 1'b0, 1'b1, 2);
        cpu_do(1'b0, 32'h6, SZ_H, 1'b0, 32'h0, 32'h00001234, 1'b0, 1'b1, 2);
        cpu_do(1'b0, 32'h4, SZ_H, 1'b0, 32'h0, 32'hFFFFAABB, 1'b0, 1'b1, 2);
        cpu_do(1'b0, 32'h4, SZ_H, 1'b1, 32'h0, 32'h0000AABB, 1'b0, 1'b1, 2);

        // Misaligned and illegal accesses: flagged, zero data, no write
        w0 = we_cnt;
        cpu_do(1'b0, 32'h6, SZ_W, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 2);
        cpu_do(1'b1, 32'h5, SZ_H, 1'b0, 32'h00005555, 32'h0, 1'b1, 1'b1, 2);
        cpu_do(1'b1, 32'h8, 2'b11, 1'b0, 32'h99999999, 32'h0, 1'b1, 1'b1, 2);
        cpu_do(1'b0, 32'h8, 2'b11, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 2);
        check("misal_we_count", we_cnt - w0, 0);
        check("misal_mem1", mem[1], 32'h1234AABB);
        check("misal_mem2", mem[2], 32'h01020304);

        // Byte store to the top lane, then an aliased word load of the same word
        cpu_do(1'b1, 32'hB, SZ_B, 1'b0, 32'hABCDEF77, 32'h0, 1'b0, 1'b0, 2);
        check("stb_mem2", mem[2], 32'h77020304);
        cpu_do(1'b0, 32'h80001008, SZ_W, 1'b0, 32'h0, 32'h77020304, 1'b0, 1'b1, 2);

        // Reset during the ACCESS cycle of a word store: write and ack suppressed
        w0 = we_cnt;
        cpu_we = 1'b1; cpu_addr = 32'h8; cpu_size = SZ_W; cpu_wdata = 32'h11112222;
        cpu_req = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("midrst_we_count", we_cnt - w0, 0);
        check("midrst_mem2", mem[2], 32'h77020304);
        cpu_do(1'b0, 32'h8, SZ_W, 1'b0, 32'h0, 32'h77020304, 1'b0, 1'b1, 2);

        repeat (3) @(posedge clk);
        check("cpu_q_drained", cpu_q.size(), 0);
        check("pdu_q_drained", pdu_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
